// File: rtl/mem_stage.sv
// Memory-access stage: accepts one instruction from EX, performs the optional
// load/store on the data-memory port, aligns/extends load data and presents a
// single-cycle write-back pulse to WB.
module mem_stage #(
    // Cycles dmem_req may stay high without ack before abort; 0 disables.
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // EX interface
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_dest,
    input  logic        ex_is_b_type,
    // Data-memory interface
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // WB interface
    output logic        wb_enable,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        wb_is_b_type,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_t;

    // Counter is 8 bits wide; a 9-bit limit lets the increment compare cleanly.
    localparam logic [8:0] LP_MAX_WAIT = MAX_WAIT[8:0];
    localparam bit LP_TIMEOUT_EN = (MAX_WAIT != 0);

    state_t      r_state, w_state_next;
    logic [7:0]  r_wait_cnt, w_wait_cnt_next;

    // Fields latched on acceptance
    logic [31:0] r_addr, w_addr_next;
    logic [1:0]  r_size, w_size_next;
    logic        r_unsigned, w_unsigned_next;
    logic        r_reg_write, w_reg_write_next;
    logic [4:0]  r_dest, w_dest_next;
    logic        r_is_b, w_is_b_next;
    logic        r_we, w_we_next;
    logic [3:0]  r_wstrb, w_wstrb_next;
    logic [31:0] r_wdata, w_wdata_next;

    // Registered WB-side outputs
    logic        r_wb_enable, w_wb_enable_next;
    logic [31:0] r_wb_data, w_wb_data_next;
    logic [4:0]  r_wb_dest, w_wb_dest_next;
    logic        r_wb_is_b, w_wb_is_b_next;
    logic        r_misalign, w_misalign_next;
    logic        r_bus_err, w_bus_err_next;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misaligned;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;
    logic [8:0]  w_wait_inc;
    logic        w_timeout;

    assign ex_ready   = (r_state == StIdle);
    assign dmem_req   = (r_state == StAccess);
    assign w_accept   = ex_valid && (r_state == StIdle);
    assign w_is_mem   = ex_mem_read || ex_mem_write;
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout  = LP_TIMEOUT_EN && (w_wait_inc == LP_MAX_WAIT);

    // Alignment check, strobes and lane replication for the incoming op
    always_comb begin
        w_misaligned = 1'b0;
        w_strb       = 4'b1111;
        w_wdata_rep  = ex_store_data;
        case (ex_mem_size)
            2'b00: begin
                w_strb      = 4'b0001 << ex_alu_result[1:0];
                w_wdata_rep = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_misaligned = ex_alu_result[0];
                w_strb       = 4'b0011 << ex_alu_result[1:0];
                w_wdata_rep  = {2{ex_store_data[15:0]}};
            end
            default: begin
                // 2'b11 is illegal and handled as a word access
                w_misaligned = |ex_alu_result[1:0];
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        w_lane = dmem_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'd0, w_lane[7:0]}
                                              : {{24{w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'd0, w_lane[15:0]}
                                              : {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    // Next-state, latching and retirement logic
    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_addr_next      = r_addr;
        w_size_next      = r_size;
        w_unsigned_next  = r_unsigned;
        w_reg_write_next = r_reg_write;
        w_dest_next      = r_dest;
        w_is_b_next      = r_is_b;
        w_we_next        = r_we;
        w_wstrb_next     = r_wstrb;
        w_wdata_next     = r_wdata;
        w_wb_enable_next = 1'b0;
        w_wb_data_next   = r_wb_data;
        w_wb_dest_next   = r_wb_dest;
        w_wb_is_b_next   = 1'b0;
        w_misalign_next  = 1'b0;
        w_bus_err_next   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_addr_next      = ex_alu_result;
                    w_size_next      = ex_mem_size;
                    w_unsigned_next  = ex_mem_unsigned;
                    w_reg_write_next = ex_reg_write;
                    w_dest_next      = ex_dest;
                    w_is_b_next      = ex_is_b_type;
                    w_we_next        = ex_mem_write;
                    w_wstrb_next     = ex_mem_write ? w_strb : 4'b0000;
                    w_wdata_next     = w_wdata_rep;
                    if (!w_is_mem) begin
                        w_wb_enable_next = ex_reg_write;
                        w_wb_data_next   = ex_alu_result;
                        w_wb_dest_next   = ex_dest;
                        w_wb_is_b_next   = ex_is_b_type;
                    end else if (w_misaligned) begin
                        w_misalign_next = 1'b1;
                    end else begin
                        w_state_next    = StAccess;
                        w_wait_cnt_next = 8'd0;
                    end
                end
            end
            StAccess: begin
                // Ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    w_state_next    = StIdle;
                    w_wait_cnt_next = 8'd0;
                    w_wb_dest_next  = r_dest;
                    w_wb_is_b_next  = r_is_b;
                    if (r_we) begin
                        w_wb_enable_next = 1'b0;
                        w_wb_data_next   = 32'd0;
                    end else begin
                        w_wb_enable_next = r_reg_write;
                        w_wb_data_next   = w_load_data;
                    end
                end else if (w_timeout) begin
                    w_state_next    = StIdle;
                    w_wait_cnt_next = 8'd0;
                    w_bus_err_next  = 1'b1;
                end else begin
                    w_wait_cnt_next = w_wait_inc[7:0];
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_wait_cnt  <= 8'd0;
            r_addr      <= 32'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_reg_write <= 1'b0;
            r_dest      <= 5'd0;
            r_is_b      <= 1'b0;
            r_we        <= 1'b0;
            r_wstrb     <= 4'd0;
            r_wdata     <= 32'd0;
            r_wb_enable <= 1'b0;
            r_wb_data   <= 32'd0;
            r_wb_dest   <= 5'd0;
            r_wb_is_b   <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_addr      <= w_addr_next;
            r_size      <= w_size_next;
            r_unsigned  <= w_unsigned_next;
            r_reg_write <= w_reg_write_next;
            r_dest      <= w_dest_next;
            r_is_b      <= w_is_b_next;
            r_we        <= w_we_next;
            r_wstrb     <= w_wstrb_next;
            r_wdata     <= w_wdata_next;
            r_wb_enable <= w_wb_enable_next;
            r_wb_data   <= w_wb_data_next;
            r_wb_dest   <= w_wb_dest_next;
            r_wb_is_b   <= w_wb_is_b_next;
            r_misalign  <= w_misalign_next;
            r_bus_err   <= w_bus_err_next;
        end
    end

    assign dmem_we      = r_we;
    assign dmem_addr    = {r_addr[31:2], 2'b00};
    assign dmem_wstrb   = r_wstrb;
    assign dmem_wdata   = r_wdata;
    assign wb_enable    = r_wb_enable;
    assign wb_data      = r_wb_data;
    assign wb_dest      = r_wb_dest;
    assign wb_is_b_type = r_wb_is_b;
    assign misalign_exc = r_misalign;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected retirements are queued when an op is
// driven and popped when the stage retires it.
module tb_mem_stage;

    localparam int unsigned MaxWait = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic        ex_reg_write;
    logic [4:0]  ex_dest;
    logic        ex_is_b_type;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_enable;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_is_b_type;
    logic        misalign_exc;
    logic        bus_err;

    mem_stage #(
        .MAX_WAIT(MaxWait)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_size    (ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned),
        .ex_reg_write   (ex_reg_write),
        .ex_dest        (ex_dest),
        .ex_is_b_type   (ex_is_b_type),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .wb_enable      (wb_enable),
        .wb_data        (wb_data),
        .wb_dest        (wb_dest),
        .wb_is_b_type   (wb_is_b_type),
        .misalign_exc   (misalign_exc),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] data;
        logic [4:0]  dest;
        logic        mis;
        logic        berr;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic rd,
                            input logic wr, input logic [1:0] size, input logic uns,
                            input logic regw, input logic [4:0] dest, input logic isb);
        ex_valid        = 1'b1;
        ex_alu_result   = alu;
        ex_store_data   = sd;
        ex_mem_read     = rd;
        ex_mem_write    = wr;
        ex_mem_size     = size;
        ex_mem_unsigned = uns;
        ex_reg_write    = regw;
        ex_dest         = dest;
        ex_is_b_type    = isb;
    endtask

    task automatic push_exp(input logic en, input logic [31:0] data, input logic [4:0] dest,
                            input logic mis, input logic berr, input logic chkd);
        exp_t e;
        e.en       = en;
        e.data     = data;
        e.dest     = dest;
        e.mis      = mis;
        e.berr     = berr;
        e.chk_data = chkd;
        sb.push_back(e);
    endtask

    // Compare the current WB-side outputs against the oldest queued expectation
    task automatic check_retire(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_en"}, wb_enable, e.en);
            chk({tag, "_mis"}, misalign_exc, e.mis);
            chk({tag, "_berr"}, bus_err, e.berr);
            if (e.chk_data) chk({tag, "_data"}, wb_data, e.data);
            if (e.en) chk({tag, "_dest"}, wb_dest, e.dest);
        end
    endtask

    // Run an already-driven aligned memory op through its ACCESS phase
    task automatic mem_access(input string tag, input int waits, input logic [31:0] addr,
                              input logic we, input logic [3:0] strb, input logic [31:0] wdata,
                              input logic [31:0] rdata);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_rdy"}, ex_ready, 0);
        chk({tag, "_addr"}, dmem_addr, addr);
        chk({tag, "_we"}, dmem_we, we);
        if (we) begin
            chk({tag, "_wstrb"}, dmem_wstrb, strb);
            chk({tag, "_wdata"}, dmem_wdata, wdata);
        end
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, "_req_wait"}, dmem_req, 1);
            chk({tag, "_addr_wait"}, dmem_addr, addr);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check_retire(tag);
        chk({tag, "_req_done"}, dmem_req, 0);
        chk({tag, "_rdy_done"}, ex_ready, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cycles;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive_op(32'd0, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0);
        ex_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_en", wb_enable, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_mis", misalign_exc, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_addr", dmem_addr, 0);
        rst = 1'b0;
        tick();

        // Back-to-back ALU ops retire one per cycle, one cycle late
        drive_op(32'h11, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1, 1'b0);
        push_exp(1'b1, 32'h11, 5'd1, 1'b0, 1'b0, 1'b1);
        tick();
        check_retire("alu1");
        drive_op(32'h22, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd2, 1'b0);
        push_exp(1'b1, 32'h22, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        check_retire("alu2");
        drive_op(32'h33, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 1'b1);
        push_exp(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        check_retire("alu3");
        chk("alu3_isb", wb_is_b_type, 1);
        ex_valid = 1'b0;
        tick();
        chk("alu_idle_en", wb_enable, 0);
        chk("alu_idle_hold", wb_data, 32'h33);
        chk("alu_idle_isb", wb_is_b_type, 0);

        // x0 destination still raises wb_enable
        drive_op(32'h55, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd0, 1'b0);
        push_exp(1'b1, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        check_retire("x0");

        // LB / LBU at 0x1003, ack after two wait cycles
        drive_op(32'h1003, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b0);
        push_exp(1'b1, 32'hFFFF_FF80, 5'd5, 1'b0, 1'b0, 1'b1);
        mem_access("lb", 2, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80FF_FF00);
        drive_op(32'h1003, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd6, 1'b0);
        push_exp(1'b1, 32'h0000_0080, 5'd6, 1'b0, 1'b0, 1'b1);
        mem_access("lbu", 2, 32'h1000, 1'b0, 4'b0000, 32'd0, 32'h80FF_FF00);

        // LH with ack in the first ACCESS cycle
        drive_op(32'h6002, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd8, 1'b0);
        push_exp(1'b1, 32'hFFFF_8001, 5'd8, 1'b0, 1'b0, 1'b1);
        mem_access("lh", 0, 32'h6000, 1'b0, 4'b0000, 32'd0, 32'h8001_1234);

        // Misaligned LW: no request, one exception pulse, data held
        drive_op(32'h3001, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd12, 1'b0);
        push_exp(1'b0, 32'hFFFF_8001, 5'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_retire("lw_mis");
        chk("lw_mis_req", dmem_req, 0);
        chk("lw_mis_rdy", ex_ready, 1);
        drive_op(32'h77, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7, 1'b0);
        push_exp(1'b1, 32'h77, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        check_retire("after_mis");

        // SH and SB: strobes, replication, no write-back
        drive_op(32'h2002, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0);
        push_exp(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        mem_access("sh", 1, 32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'd0);
        drive_op(32'h2001, 32'h0000_00EF, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        push_exp(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        mem_access("sb", 0, 32'h2000, 1'b1, 4'b0010, 32'hEFEF_EFEF, 32'd0);

        // Timeout: request stays up MaxWait cycles, then one bus_err pulse
        drive_op(32'h4000, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9, 1'b0);
        push_exp(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        ex_valid   = 1'b0;
        req_cycles = 0;
        while (dmem_req === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", req_cycles, MaxWait);
        check_retire("to");
        chk("to_rdy", ex_ready, 1);
        tick();
        chk("to_berr_pulse", bus_err, 0);

        // Asynchronous reset while a request is outstanding
        drive_op(32'h5000, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd10, 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("rmid_req_before", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rmid_req", dmem_req, 0);
        chk("rmid_rdy", ex_ready, 1);
        #2;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rmid_late_ack_en", wb_enable, 0);
        chk("rmid_late_ack_req", dmem_req, 0);
        chk("rmid_wb_data", wb_data, 0);
        dmem_ack = 1'b0;
        tick();
        chk("rmid_late_ack_en2", wb_enable, 0);

        // Stage still works after the mid-access reset
        drive_op(32'h99, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd11, 1'b0);
        push_exp(1'b1, 32'h99, 5'd11, 1'b0, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        check_retire("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the mysoc five-stage core. It sits between EX and WB. It accepts one instruction at a time from EX over a valid/ready handshake and performs any load or store on the data-memory port using a req/ack handshake. It aligns and extends load data, then presents wb_enable/wb_data/wb_dest/wb_is_b_type to the WB stage for exactly one cycle per retired instruction.

Parameters:
MAX_WAIT, 255, maximum cycles dmem_req may stay high without dmem_ack before the access is aborted (8-bit counter; 0 disables the timeout)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
ex_valid  input  1  EX presents an instruction
ex_ready  output  1  MEM accepts an instruction this cycle
ex_alu_result  input  32  ALU result, or effective address for load/store
ex_store_data  input  32  rs2 value for stores
ex_mem_read  input  1  instruction is a load
ex_mem_write  input  1  instruction is a store (never both with ex_mem_read)
ex_mem_size  input  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
ex_mem_unsigned  input  1  zero-extend load result (LBU/LHU)
ex_reg_write  input  1  instruction writes rd
ex_dest  input  5  rd index
ex_is_b_type  input  1  branch instruction marker, passed through
dmem_req  output  1  data-memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wstrb  output  4  byte write strobes
dmem_wdata  output  32  store data, lane-replicated
dmem_ack  input  1  memory completes the request this cycle
dmem_rdata  input  32  read data, valid when dmem_ack=1
wb_enable  output  1  register write enable to WB
wb_data  output  32  write-back data
wb_dest  output  5  write-back register index
wb_is_b_type  output  1  branch marker to WB
misalign_exc  output  1  one-cycle pulse: misaligned access, dropped
bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0 except ex_ready=1. The wait counter and latched fields clear. An in-flight request is abandoned, dmem_req drops immediately, and a later dmem_ack is ignored.
- States are IDLE and ACCESS. ex_ready=1 only in IDLE.
- Acceptance happens on ex_valid&ex_ready at the clock edge. All ex_* fields are latched on acceptance.
- Non-memory op accepted in IDLE: the next cycle shows wb_enable=ex_reg_write, wb_data=ex_alu_result, wb_dest, wb_is_b_type (latency 1). The FSM stays in IDLE, so back-to-back acceptance gives one retirement per cycle.
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned. The access is not issued. Next cycle: misalign_exc=1, wb_enable=0. The FSM stays in IDLE.
- Aligned memory op: next cycle the FSM is in ACCESS, and dmem_req=1 with dmem_addr/dmem_we/dmem_wstrb/dmem_wdata registered. These stay stable until ack. dmem_ack may arrive in the first ACCESS cycle.
- Store strobes: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111. dmem_wdata: byte → {4{sd[7:0]}}, half → {2{sd[15:0]}}, word → sd.
- Load extract: lane = dmem_rdata>>(8*addr[1:0]). Byte and half results are sign-extended unless ex_mem_unsigned=1.
- On dmem_ack in ACCESS: dmem_req drops the same cycle (combinational from state). Next cycle the FSM is in IDLE with the WB outputs valid for one cycle. For a load, wb_enable=ex_reg_write and wb_data=extracted value. For a store, wb_enable=0 and wb_data=0.
- Timeout: the counter increments each ACCESS cycle without ack. When it reaches MAX_WAIT (MAX_WAIT≠0), the FSM returns to IDLE and the next cycle shows bus_err=1 and wb_enable=0.
- If ack and timeout occur in the same cycle, ack wins.
- wb_enable, misalign_exc and bus_err are single-cycle pulses and are 0 whenever no retirement occurs. wb_dest/wb_data hold their last values when wb_enable=0.
- x0: wb_enable passes through unchanged for dest 0; WB forces the data to zero.

Test Plan:
- Reset mid-ACCESS: assert rst while dmem_req=1 → dmem_req=0 and ex_ready=1 within the same cycle; a dmem_ack arriving after reset release produces no wb_enable.
- ALU stream: 3 back-to-back non-mem ops, dest 1/2/3, results 0x11/0x22/0x33 → wb_enable high 3 consecutive cycles, each delayed 1 cycle, with matching data and dest.
- LB at addr 0x1003 with rdata 0x80FF_FF00 and ack after 2 wait cycles → dmem_addr=0x1000, wb_data=0xFFFF_FF80; the same access as LBU → 0x0000_0080.
- SH at addr 0x2002 with store data 0x1234_ABCD → dmem_wstrb=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_enable=0 after ack.
- LW at addr 0x3001 → no dmem_req, misalign_exc pulse, wb_enable=0; the next op is accepted normally.
- MAX_WAIT=4, ack never returns → dmem_req high exactly 4 cycles, then one bus_err pulse and ex_ready=1.
